// File: rtl/hpdcache_repl_pkg.sv
// Shared types for the replacement controller: FSM states, set/way vectors, index-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hpdcache_repl_pkg;

  localparam int unsigned HPDCACHE_SETS  = 64;
  localparam int unsigned HPDCACHE_WAYS  = 4;
  localparam int unsigned HPDCACHE_SET_W = $clog2(HPDCACHE_SETS);

  typedef logic [HPDCACHE_SET_W-1:0] set_t;
  typedef logic [HPDCACHE_WAYS-1:0]  way_vector_t;

  typedef enum logic [1:0] {
    REPL_IDLE   = 2'd0,
    REPL_LOOKUP = 2'd1,
    REPL_EVICT  = 2'd2,
    REPL_RESP   = 2'd3
  } repl_state_e;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, pointer starts at requester 0.
// Latency: grant is combinational; pointer moves on the cycle advance_i is high.
// Backpressure: none; pointer holds until the grant is consumed via advance_i.
module hpdcache_rr_arbiter
  import hpdcache_repl_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // Scan requesters starting at the pointer; first active one wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_idx = IW'((int'(r_ptr) + k) % int'(N));
      if (!w_found && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        gnt_idx_o    = w_idx;
        w_found      = 1'b1;
      end
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (advance_i && w_found) begin
      r_ptr <= (int'(gnt_idx_o) == int'(N) - 1) ? '0 : gnt_idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/hpdcache_repl_ctrl.sv
// Allocation controller: arbitrates requesters, reads the directory, picks a victim, evicts dirty lines, responds.
// Latency: grant->rsp_valid_o is 2 cycles clean, 3 cycles plus evict_ready_i stall for a dirty victim.
// Backpressure: one allocation in flight; evict_valid_o/rsp_valid_o hold until accepted, no grant meanwhile.
module hpdcache_repl_ctrl
  import hpdcache_repl_pkg::*;
#(
  parameter  int unsigned SETS = HPDCACHE_SETS,
  parameter  int unsigned WAYS = HPDCACHE_WAYS,
  parameter  int unsigned REQS = 2,
  localparam int unsigned SW   = $clog2(SETS),
  localparam int unsigned RW   = idx_width(REQS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REQS-1:0]   req_valid_i,
  output logic [REQS-1:0]   req_ready_o,
  input  logic [REQS*SW-1:0] req_set_i,
  output logic              dir_rd_o,
  output logic [SW-1:0]     dir_rd_set_o,
  input  logic [WAYS-1:0]   dir_valid_i,
  input  logic [WAYS-1:0]   dir_wb_i,
  input  logic [WAYS-1:0]   dir_dirty_i,
  output logic [WAYS-1:0]   sel_dir_valid_o,
  output logic [WAYS-1:0]   sel_dir_wb_o,
  output logic [WAYS-1:0]   sel_dir_dirty_o,
  output logic [SW-1:0]     sel_set_o,
  input  logic [WAYS-1:0]   sel_victim_way_i,
  output logic              repl_o,
  output logic [SW-1:0]     repl_set_o,
  output logic [WAYS-1:0]   repl_way_o,
  output logic              evict_valid_o,
  input  logic              evict_ready_i,
  output logic [SW-1:0]     evict_set_o,
  output logic [WAYS-1:0]   evict_way_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [RW-1:0]     rsp_id_o,
  output logic [WAYS-1:0]   rsp_way_o,
  output logic              rsp_err_o
);

  repl_state_e     r_state;
  repl_state_e     w_state_nxt;
  logic [SW-1:0]   r_set;
  logic [RW-1:0]   r_id;
  logic [WAYS-1:0] r_way;
  logic            r_err;

  logic            w_grant;
  logic [REQS-1:0] w_gnt;
  logic [RW-1:0]   w_gnt_idx;
  logic [SW-1:0]   w_req_set;
  logic            w_victim_any;
  logic            w_victim_dirty;

  // A grant is only issued from IDLE and never while reset is held.
  assign w_grant        = (r_state == REPL_IDLE) && (|req_valid_i) && !rst_i;
  assign w_req_set      = req_set_i[int'(w_gnt_idx)*int'(SW) +: SW];
  assign w_victim_any   = |sel_victim_way_i;
  // Only a valid line that is also dirty needs a write-back.
  assign w_victim_dirty = |(sel_victim_way_i & dir_valid_i & dir_dirty_i);

  hpdcache_rr_arbiter #(
    .N (REQS)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .advance_i (w_grant),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  // Next-state and output decode; everything forced to 0 while reset is held.
  always_comb begin
    w_state_nxt     = r_state;
    req_ready_o     = '0;
    dir_rd_o        = 1'b0;
    dir_rd_set_o    = '0;
    sel_dir_valid_o = '0;
    sel_dir_wb_o    = '0;
    sel_dir_dirty_o = '0;
    sel_set_o       = '0;
    repl_o          = 1'b0;
    repl_set_o      = '0;
    repl_way_o      = '0;
    evict_valid_o   = 1'b0;
    evict_set_o     = '0;
    evict_way_o     = '0;
    rsp_valid_o     = 1'b0;
    rsp_id_o        = '0;
    rsp_way_o       = '0;
    rsp_err_o       = 1'b0;
    if (!rst_i) begin
      case (r_state)
        REPL_IDLE: begin
          if (w_grant) begin
            req_ready_o  = w_gnt;
            dir_rd_o     = 1'b1;
            dir_rd_set_o = w_req_set;
            w_state_nxt  = REPL_LOOKUP;
          end
        end
        REPL_LOOKUP: begin
          sel_dir_valid_o = dir_valid_i;
          sel_dir_wb_o    = dir_wb_i;
          sel_dir_dirty_o = dir_dirty_i;
          sel_set_o       = r_set;
          if (w_victim_any) begin
            repl_o     = 1'b1;
            repl_set_o = r_set;
            repl_way_o = sel_victim_way_i;
          end
          w_state_nxt = (w_victim_any && w_victim_dirty) ? REPL_EVICT : REPL_RESP;
        end
        REPL_EVICT: begin
          evict_valid_o = 1'b1;
          evict_set_o   = r_set;
          evict_way_o   = r_way;
          if (evict_ready_i) w_state_nxt = REPL_RESP;
        end
        REPL_RESP: begin
          rsp_valid_o = 1'b1;
          rsp_id_o    = r_id;
          rsp_way_o   = r_way;
          rsp_err_o   = r_err;
          if (rsp_ready_i) w_state_nxt = REPL_IDLE;
        end
        default: w_state_nxt = REPL_IDLE;
      endcase
    end
  end

  // State register plus transaction latches (requester, set, victim, error).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= REPL_IDLE;
      r_set   <= '0;
      r_id    <= '0;
      r_way   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_id  <= w_gnt_idx;
        r_set <= w_req_set;
      end
      if (r_state == REPL_LOOKUP) begin
        r_way <= sel_victim_way_i;
        r_err <= !w_victim_any;
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_repl_ctrl.sv
// Self-checking bench for hpdcache_repl_ctrl with scoreboard queues for grants, commits, evictions, responses.
// Latency: checks 2-cycle clean and 3+stall dirty grant-to-response timing.
// Backpressure: exercises evict_ready_i and rsp_ready_i stalls plus reset mid-transaction.
module tb_hpdcache_repl_ctrl;

  localparam int SW   = 6;
  localparam int WAYS = 4;
  localparam int REQS = 2;

  typedef struct { int id; int set; } gnt_exp_t;
  typedef struct { int set; int way; int val; int dty; int wb; } repl_exp_t;
  typedef struct { int id; int way; int err; int lat; } rsp_exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [REQS-1:0]      req_valid;
  logic [REQS-1:0]      req_ready;
  logic [REQS*SW-1:0]   req_set;
  logic                 dir_rd;
  logic [SW-1:0]        dir_rd_set;
  logic [WAYS-1:0]      dir_valid, dir_wb, dir_dirty;
  logic [WAYS-1:0]      sel_valid, sel_wb, sel_dirty;
  logic [SW-1:0]        sel_set;
  logic [WAYS-1:0]      victim;
  logic                 repl;
  logic [SW-1:0]        repl_set;
  logic [WAYS-1:0]      repl_way;
  logic                 evict_valid, evict_ready;
  logic [SW-1:0]        evict_set;
  logic [WAYS-1:0]      evict_way;
  logic                 rsp_valid, rsp_ready;
  logic [0:0]           rsp_id;
  logic [WAYS-1:0]      rsp_way;
  logic                 rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_ptr    = 0;

  gnt_exp_t  q_gnt[$];
  repl_exp_t q_repl[$];
  repl_exp_t q_ev[$];
  rsp_exp_t  q_rsp[$];

  hpdcache_repl_ctrl #(.SETS(64), .WAYS(WAYS), .REQS(REQS)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_set_i(req_set),
    .dir_rd_o(dir_rd), .dir_rd_set_o(dir_rd_set),
    .dir_valid_i(dir_valid), .dir_wb_i(dir_wb), .dir_dirty_i(dir_dirty),
    .sel_dir_valid_o(sel_valid), .sel_dir_wb_o(sel_wb), .sel_dir_dirty_o(sel_dirty),
    .sel_set_o(sel_set), .sel_victim_way_i(victim),
    .repl_o(repl), .repl_set_o(repl_set), .repl_way_o(repl_way),
    .evict_valid_o(evict_valid), .evict_ready_i(evict_ready),
    .evict_set_o(evict_set), .evict_way_o(evict_way),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_way_o(rsp_way), .rsp_err_o(rsp_err)
  );

  wire any_out = |{req_ready, dir_rd, dir_rd_set, sel_valid, sel_wb, sel_dirty, sel_set,
                   repl, repl_set, repl_way, evict_valid, evict_set, evict_way,
                   rsp_valid, rsp_id, rsp_way, rsp_err};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: compare DUT activity against the scoreboard queues.
  int        t_grant = 0;
  int        t_rsp   = 0;
  bit        p_ev    = 1'b0;
  bit        p_rsp   = 1'b0;
  int        p_ev_set, p_ev_way, p_rsp_id, p_rsp_way, p_rsp_err;
  gnt_exp_t  eg;
  repl_exp_t er;
  rsp_exp_t  es;

  always @(negedge clk) begin
    if (rst) begin
      p_ev  = 1'b0;
      p_rsp = 1'b0;
    end else begin
      if (req_ready != 0) begin
        if (q_gnt.size() == 0) check_eq("unexpected_grant", int'(req_ready), 0);
        else begin
          eg = q_gnt.pop_front();
          check_eq("grant", int'(req_ready), 1 << eg.id);
          check_eq("dir_rd", int'(dir_rd), 1);
          check_eq("dir_rd_set", int'(dir_rd_set), eg.set);
          t_grant = cyc;
        end
      end
      if (repl) begin
        if (q_repl.size() == 0) check_eq("unexpected_repl", 1, 0);
        else begin
          er = q_repl.pop_front();
          check_eq("repl_set", int'(repl_set), er.set);
          check_eq("repl_way", int'(repl_way), er.way);
          check_eq("repl_lat", cyc - t_grant, 1);
          check_eq("sel_set", int'(sel_set), er.set);
          check_eq("sel_valid", int'(sel_valid), er.val);
          check_eq("sel_dirty", int'(sel_dirty), er.dty);
          check_eq("sel_wb", int'(sel_wb), er.wb);
        end
      end
      if (evict_valid || rsp_valid) check_eq("busy_no_grant", int'(req_ready), 0);
      if (evict_valid && p_ev) begin
        check_eq("evict_set_stable", int'(evict_set), p_ev_set);
        check_eq("evict_way_stable", int'(evict_way), p_ev_way);
      end
      if (evict_valid && evict_ready) begin
        if (q_ev.size() == 0) check_eq("unexpected_evict", 1, 0);
        else begin
          er = q_ev.pop_front();
          check_eq("evict_set", int'(evict_set), er.set);
          check_eq("evict_way", int'(evict_way), er.way);
        end
      end
      p_ev = evict_valid && !evict_ready;
      p_ev_set = int'(evict_set);
      p_ev_way = int'(evict_way);
      if (rsp_valid && !p_rsp) t_rsp = cyc;
      if (rsp_valid && p_rsp) begin
        check_eq("rsp_id_stable", int'(rsp_id), p_rsp_id);
        check_eq("rsp_way_stable", int'(rsp_way), p_rsp_way);
        check_eq("rsp_err_stable", int'(rsp_err), p_rsp_err);
      end
      if (rsp_valid && rsp_ready) begin
        if (q_rsp.size() == 0) check_eq("unexpected_rsp", 1, 0);
        else begin
          es = q_rsp.pop_front();
          check_eq("rsp_id", int'(rsp_id), es.id);
          check_eq("rsp_way", int'(rsp_way), es.way);
          check_eq("rsp_err", int'(rsp_err), es.err);
          check_eq("rsp_lat", t_rsp - t_grant, es.lat);
        end
      end
      p_rsp = rsp_valid && !rsp_ready;
      p_rsp_id = int'(rsp_id);
      p_rsp_way = int'(rsp_way);
      p_rsp_err = int'(rsp_err);
    end
  end

  // Reference round-robin: first active requester at or after the pointer.
  task automatic model_grant(input logic [1:0] mask, output int g);
    logic [1:0] m;
    m = mask;
    g = m[m_ptr] ? m_ptr : 1 - m_ptr;
    m_ptr = (g + 1) % REQS;
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq("grant_timeout", 0, 1);
  endtask

  // One allocation; entered and left at #1 after a rising edge.
  task automatic alloc(input logic [1:0] mask, input int s0, input int s1,
                       input logic [3:0] val, input logic [3:0] dty, input logic [3:0] wb,
                       input logic [3:0] vic, input int ev_stall, input int rsp_stall,
                       input bit keep);
    int  g, sg;
    bit  dirty, got;
    model_grant(mask, g);
    sg    = (g == 1) ? s1 : s0;
    dirty = |(vic & val & dty);
    q_gnt.push_back('{g, sg});
    if (vic != 0) q_repl.push_back('{sg, int'(vic), int'(val), int'(dty), int'(wb)});
    if (dirty) q_ev.push_back('{sg, int'(vic), 0, 0, 0});
    q_rsp.push_back('{g, int'(vic), (vic == 0) ? 1 : 0, dirty ? 3 + ev_stall : 2});
    req_valid = mask;
    req_set[SW-1:0]    = s0[SW-1:0];
    req_set[2*SW-1:SW] = s1[SW-1:0];
    dir_valid = val; dir_dirty = dty; dir_wb = wb; victim = vic;
    evict_ready = 1'b0; rsp_ready = 1'b0;
    wait_grant(got);
    if (!got) return;
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
    @(posedge clk); #1;
    if (dirty) begin
      repeat (ev_stall) begin @(posedge clk); #1; end
      evict_ready = 1'b1;
      @(posedge clk); #1;
      evict_ready = 1'b0;
    end
    repeat (rsp_stall) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int g;
    rst = 1'b1; req_valid = 2'b11; req_set = '0;
    dir_valid = '0; dir_wb = '0; dir_dirty = '0; victim = 4'b0001;
    evict_ready = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("out_during_reset", int'(any_out), 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    check_eq("out_after_reset", int'(any_out), 0);
    @(posedge clk); #1;

    // Both requesters held: grants alternate 0,1,0,1 from reset.
    alloc(2'b11, 5, 63, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1);
    alloc(2'b11, 5, 63, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 0, 0, 1);
    alloc(2'b11, 5, 63, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 0, 0, 1);
    alloc(2'b11, 5, 63, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0, 0);
    // Empty set, clean victim.
    alloc(2'b01, 5, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0);
    // Dirty victim with 3 stall cycles on the write-back.
    alloc(2'b01, 17, 0, 4'b1111, 4'b0100, 4'b1111, 4'b0100, 3, 0, 0);
    // Dirty bit on another way, and dirty-but-invalid victim: both clean.
    alloc(2'b10, 0, 33, 4'b1111, 4'b1000, 4'b1111, 4'b0100, 0, 0, 0);
    alloc(2'b10, 0, 0, 4'b1011, 4'b0100, 4'b0000, 4'b0100, 0, 0, 0);
    // No victim available.
    alloc(2'b01, 12, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // Response back-pressure with both requesters waiting.
    alloc(2'b11, 3, 40, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 0, 5, 1);
    alloc(2'b11, 3, 40, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 1, 2, 0);

    // Reset while in EVICT: transaction dropped, pointer back to requester 0.
    model_grant(2'b01, g);
    q_gnt.push_back('{g, 7});
    q_repl.push_back('{7, 2, 15, 2, 15});
    req_valid = 2'b01; req_set = '0; req_set[SW-1:0] = 6'd7;
    dir_valid = 4'b1111; dir_dirty = 4'b0010; dir_wb = 4'b1111; victim = 4'b0010;
    wait_grant(got);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("evict_before_rst", int'(evict_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("out_in_mid_rst", int'(any_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    check_eq("out_after_mid_rst", int'(any_out), 0);
    @(posedge clk); #1;
    alloc(2'b11, 9, 21, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1);
    alloc(2'b11, 9, 21, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("idle_outputs", int'(any_out), 0);
    check_eq("q_gnt_empty", q_gnt.size(), 0);
    check_eq("q_repl_empty", q_repl.size(), 0);
    check_eq("q_ev_empty", q_ev.size(), 0);
    check_eq("q_rsp_empty", q_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdcache_repl_ctrl.md
HPDCACHE_REPL_CTRL -- requirements
Module: hpdcache_repl_ctrl

Interface
REQ-001 The block SHALL have parameter SETS, default 64, meaning the number of cache sets (minimum 2).
REQ-002 The block SHALL have parameter WAYS, default 4, meaning the associativity.
REQ-003 The block SHALL have parameter REQS, default 2, meaning the number of allocation requesters.
REQ-004 SW = clog2(SETS) and RW = max(1, clog2(REQS)) SHALL be the derived widths.
REQ-005 The block SHALL have these ports, one per line (name  direction  width  meaning):
 clk_i  in  1  clock
 rst_i  in  1  synchronous active-high reset
 req_valid_i  in  REQS  allocation request per requester
 req_ready_o  out  REQS  one-hot grant, asserted in the acceptance cycle
 req_set_i  in  REQS*SW  packed target set per requester
 dir_rd_o  out  1  directory read strobe
 dir_rd_set_o  out  SW  set being read
 dir_valid_i  in  WAYS  directory valid bits, one cycle after dir_rd_o
 dir_wb_i  in  WAYS  write-back policy bits, same timing
 dir_dirty_i  in  WAYS  dirty bits, same timing
 sel_dir_valid_o  out  WAYS  valid bits forwarded to the victim selector
 sel_dir_wb_o  out  WAYS  wb bits forwarded to the victim selector
 sel_dir_dirty_o  out  WAYS  dirty bits forwarded to the victim selector
 sel_set_o  out  SW  set presented to the victim selector
 sel_victim_way_i  in  WAYS  one-hot victim, combinational response
 repl_o  out  1  replacement-policy commit pulse
 repl_set_o  out  SW  commit set
 repl_way_o  out  WAYS  commit way
 evict_valid_o  out  1  dirty-victim write-back request
 evict_ready_i  in  1  write-back accepted
 evict_set_o  out  SW  evicted set
 evict_way_o  out  WAYS  evicted way
 rsp_valid_o  out  1  allocation response
 rsp_ready_i  in  1  response accepted
 rsp_id_o  out  RW  requester index
 rsp_way_o  out  WAYS  allocated way
 rsp_err_o  out  1  no victim available

Function
REQ-006 The FSM SHALL have states IDLE, LOOKUP, EVICT and RESP, with one allocation in flight at a time.
REQ-007 IDLE: when any req_valid_i is set, the block SHALL grant exactly one requester round-robin, assert req_ready_o for that requester for one cycle, assert dir_rd_o with that requester's set, latch the id and set, and go to LOOKUP.
REQ-008 The round-robin pointer SHALL move to the requester after the one granted; after reset, requester 0 has highest priority.
REQ-009 LOOKUP (exactly one cycle): the block SHALL drive sel_dir_*_o directly from dir_*_i and sel_set_o from the latched set, then register the victim and its dirty bit.
REQ-010 LOOKUP with a nonzero victim: the block SHALL pulse repl_o for one cycle with the latched set and the victim way.
REQ-011 LOOKUP next state: if the victim way's valid and dirty bits are both 1, go to EVICT; otherwise go to RESP.
REQ-012 LOOKUP with a zero victim: the block SHALL not pulse repl_o, SHALL set rsp_err_o=1 and rsp_way_o=0, and go to RESP.
REQ-013 EVICT: the block SHALL hold evict_valid_o=1 and keep evict_set_o/evict_way_o stable until evict_ready_i; on the handshake cycle go to RESP.
REQ-014 RESP: the block SHALL hold rsp_valid_o=1 and keep rsp_id_o/rsp_way_o/rsp_err_o stable until rsp_ready_i; on the handshake go to IDLE. A new grant is not allowed in the same cycle.
REQ-015 Minimum latency from grant to rsp_valid_o SHALL be 2 cycles for a clean victim, and 3 cycles plus evict back-pressure for a dirty victim.
REQ-016 When idle, dir_rd_o, repl_o, evict_valid_o and rsp_valid_o SHALL be 0, and req_ready_o SHALL be 0 outside IDLE.
REQ-017 A requester that drops req_valid_i before it is granted SHALL lose nothing; requests are not latched before grant.

Reset
REQ-018 While rst_i=1 at a clk_i edge, the block SHALL go to IDLE and clear the round-robin pointer and all latches.
REQ-019 During and after reset, every output SHALL be 0.
REQ-020 Reset asserted in LOOKUP, EVICT or RESP SHALL abandon the transaction, with no repl_o pulse and no response.

Structure
REQ-021 The state enum and set_t/way_vector_t widths SHALL live in package hpdcache_repl_pkg.
REQ-022 Round-robin grant SHALL be a sub-module hpdcache_rr_arbiter (N, req, advance, one-hot gnt).

Verification
REQ-023 Req0 to set 5 with dir_valid=0000 and selector returning 0001: dir_rd_o in cycle 0, repl_o set5/0001 in cycle 1, rsp id0/way0001/err0 in cycle 2.
REQ-024 req_valid=11 held for 4 allocations: grants SHALL follow 0,1,0,1.
REQ-025 Dirty victim 0100 (valid=1111, dirty=0100, wb=1111), evict_ready_i low 3 cycles: evict_valid_o held 3 cycles then handshake; rsp one cycle later.
REQ-026 Selector returns 0000: no repl_o, rsp_err_o=1, rsp_way_o=0000.
REQ-027 rsp_ready_i low 5 cycles with req_valid=11: rsp held stable, no grant until the handshake.
REQ-028 rst_i pulsed in EVICT: next cycle all outputs 0; subsequent req1 granted only after req0 is retried, since the pointer is reset.
